// File: rtl/ram_rd_stream.sv
// Streams LEN words from a synchronous block RAM starting at BASE as a valid/ready stream.
// RAM read latency is absorbed by a credit-limited in-flight pipe feeding a small output FIFO.
module ram_rd_stream #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned LEN_W  = ADDR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              last_o,
    input  logic              ready_i
);

    localparam int unsigned BUF_D = RD_LAT + 2;
    localparam int unsigned PTR_W = $clog2(BUF_D);
    localparam int unsigned CNT_W = $clog2(BUF_D + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e              state_q;
    logic                busy_q;
    logic                done_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    rem_q;
    logic [ADDR_W-1:0]   rd_addr_q;

    // issued_q is aligned with rd_addr_q; the pipe then covers the RAM latency
    logic                issued_q;
    logic                issued_last_q;
    logic [RD_LAT-1:0]   pipe_vld_q;
    logic [RD_LAT-1:0]   pipe_last_q;

    logic [DATA_W-1:0]   fifo_data_q [BUF_D];
    logic [BUF_D-1:0]    fifo_last_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                push;
    logic                pop;
    logic                issue;
    logic                issue_last;
    logic                drained;
    logic [CNT_W-1:0]    inflight;
    logic [OCC_W-1:0]    occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        inflight = CNT_W'(issued_q);
        for (int i = 0; i < int'(RD_LAT); i++) begin
            inflight = inflight + CNT_W'(pipe_vld_q[i]);
        end
    end

    assign push = pipe_vld_q[RD_LAT-1];
    assign pop  = (cnt_q != '0) && ready_i;

    // A word popping this clock frees its credit now, which keeps one word/clk sustained
    assign occ  = OCC_W'(inflight) + OCC_W'(cnt_q) - OCC_W'(pop);

    assign issue      = (state_q == StRun) && (rem_q != '0) && (occ < OCC_W'(BUF_D));
    assign issue_last = issue && (rem_q == LEN_W'(1));
    assign drained    = (inflight == '0) &&
                        ((cnt_q == '0) || ((cnt_q == CNT_W'(1)) && pop));

    // Control FSM; zero-length requests pass through RUN and DRAIN without issuing,
    // so done_o lands two clocks after the start is accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            addr_q        <= '0;
            rem_q         <= '0;
            rd_addr_q     <= '0;
            issued_q      <= 1'b0;
            issued_last_q <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            issued_q      <= issue;
            issued_last_q <= issue_last;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        addr_q  <= base_i;
                        rem_q   <= len_i;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (issue) begin
                        rd_addr_q <= addr_q;
                        addr_q    <= addr_q + ADDR_W'(1);
                        rem_q     <= rem_q - LEN_W'(1);
                    end
                    if ((rem_q == '0) || issue_last) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drained) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            pipe_vld_q[0]  <= issued_q;
            pipe_last_q[0] <= issued_last_q;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(BUF_D); i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= rd_data_i;
                fifo_last_q[wr_ptr_q] <= pipe_last_q[RD_LAT-1];
                wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rd_addr_o = rd_addr_q;
    assign data_o    = fifo_data_q[rd_ptr_q];
    assign last_o    = fifo_last_q[rd_ptr_q];
    assign valid_o   = (cnt_q != '0);

endmodule

// File: tb/tb_ram_rd_stream.sv
// Directed bench for ram_rd_stream: one instance with RD_LAT=2 and one with RD_LAT=1,
// both driven by the same stimulus, each fed by its own RAM model.
module tb_ram_rd_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] base;
    logic [13:0] len;
    logic        ready;
    logic        sel;

    logic        busy2, done2, valid2, last2;
    logic [12:0] addr2;
    logic [15:0] rdat2, data2;
    logic        busy1, done1, valid1, last1;
    logic [12:0] addr1;
    logic [15:0] rdat1, data1;

    logic        v_busy, v_done, v_valid, v_last;
    logic [12:0] v_addr;
    logic [15:0] v_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_rd_stream #(.DATA_W(16), .ADDR_W(13), .RD_LAT(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_i(base), .len_i(len),
        .busy_o(busy2), .done_o(done2), .rd_addr_o(addr2), .rd_data_i(rdat2),
        .data_o(data2), .valid_o(valid2), .last_o(last2), .ready_i(ready)
    );

    ram_rd_stream #(.DATA_W(16), .ADDR_W(13), .RD_LAT(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_i(base), .len_i(len),
        .busy_o(busy1), .done_o(done1), .rd_addr_o(addr1), .rd_data_i(rdat1),
        .data_o(data1), .valid_o(valid1), .last_o(last1), .ready_i(ready)
    );

    // Odd multiplier makes every address map to a distinct word
    function automatic logic [15:0] mem_word(input logic [12:0] a);
        logic [15:0] w;
        w = {3'b000, a} * 16'h9E37;
        return w ^ 16'h1234;
    endfunction

    logic [15:0] ram2_s1, ram2_s2, ram1_s1;
    always @(posedge clk) begin
        ram2_s1 <= mem_word(addr2);
        ram2_s2 <= ram2_s1;
        ram1_s1 <= mem_word(addr1);
    end
    assign rdat2 = ram2_s2;
    assign rdat1 = ram1_s1;

    assign v_busy  = sel ? busy1  : busy2;
    assign v_done  = sel ? done1  : done2;
    assign v_valid = sel ? valid1 : valid2;
    assign v_last  = sel ? last1  : last2;
    assign v_addr  = sel ? addr1  : addr2;
    assign v_data  = sel ? data1  : data2;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // mode 0: ready held high; 1: ready low 10 clks after first valid, then random;
    // 2: as mode 0 plus a start pulse while busy that must be ignored.
    task automatic run_xfer(input logic [12:0] b, input int n, input int mode);
        int          cyc, nrecv, nissue, ndone, outst, max_outst, stall, lat, budget, exp_mo;
        logic [12:0] prev_addr, exp_addr;
        logic [16:0] prev_word;
        logic        prev_stall, seen_valid, finished;
        lat        = sel ? 1 : 2;
        exp_mo     = (n < lat + 2) ? n : lat + 2;
        nrecv      = 0;
        nissue     = 0;
        ndone      = 0;
        max_outst  = 0;
        stall      = 0;
        prev_stall = 1'b0;
        prev_word  = '0;
        seen_valid = 1'b0;
        finished   = 1'b0;
        budget     = 4 * n + 200;
        prev_addr  = v_addr;
        ready      = (mode != 1);
        start      = 1'b1;
        base       = b;
        len        = 14'(n);
        @(posedge clk); #1;
        start = 1'b0;
        check_val("busy_after_start", v_busy, 1);
        cyc = 0;
        while (!finished && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (v_addr != prev_addr) begin
                nissue++;
                prev_addr = v_addr;
            end
            outst = nissue - nrecv;
            if (outst > max_outst) max_outst = outst;
            if (mode != 1 && cyc <= n) begin
                exp_addr = b + 13'(cyc - 1);
                check_val("rd_addr", v_addr, exp_addr);
            end
            if (prev_stall) begin
                check_val("hold_valid", v_valid, 1);
                check_val("hold_word", {v_last, v_data}, prev_word);
            end
            if (mode == 1) begin
                if (v_valid) seen_valid = 1'b1;
                if (!seen_valid) ready = 1'b0;
                else if (stall < 10) begin
                    ready = 1'b0;
                    stall++;
                end else ready = 1'($urandom_range(0, 1));
            end
            start = (mode == 2 && cyc == 2);
            if (start) begin
                base = 13'h0500;
                len  = 14'd3;
            end
            prev_stall = v_valid && !ready;
            prev_word  = {v_last, v_data};
            if (v_valid && nrecv >= n) check_val("extra_word", v_valid, 0);
            else if (v_valid && ready) begin
                check_val("data", v_data, mem_word(b + 13'(nrecv)));
                check_val("last", v_last, (nrecv == n - 1));
                if (mode != 1 && nrecv == 0) check_val("first_valid_clk", cyc, lat + 2);
                nrecv++;
            end
            if (v_done) begin
                ndone++;
                if (mode != 1) check_val("done_clk", cyc, (n == 0) ? 2 : lat + 2 + n);
                check_val("recv_at_done", nrecv, n);
                finished = 1'b1;
            end
        end
        start = 1'b0;
        check_val("done_seen", ndone, 1);
        check_val("issued", nissue, n);
        check_val("max_outstanding", max_outst, exp_mo);
        if (n == 0) check_val("addr_unchanged", v_addr, prev_addr);
        @(posedge clk); #1;
        check_val("done_pulse_end", v_done, 0);
        check_val("busy_idle", v_busy, 0);
        check_val("valid_idle", v_valid, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        base  = '0;
        len   = '0;
        ready = 1'b0;
        sel   = 1'b0;
        #1;
        check_val("rst_busy", busy2, 0);
        check_val("rst_done", done2, 0);
        check_val("rst_addr", addr2, 0);
        check_val("rst_data", data2, 0);
        check_val("rst_valid", valid2, 0);
        check_val("rst_last", last2, 0);
        check_val("rst_valid_lat1", valid1, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_xfer(13'h0010, 4, 0);
        run_xfer(13'h1FFE, 4, 0);
        run_xfer(13'h0100, 16, 1);
        ready = 1'b1;
        run_xfer(13'h0777, 0, 0);
        run_xfer(13'h0200, 8, 2);

        // Reset in the middle of a transfer with words buffered and in flight
        ready = 1'b1;
        start = 1'b1;
        base  = 13'h0400;
        len   = 14'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("pre_reset_valid", valid2, 1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_busy", busy2, 0);
        check_val("mid_rst_valid", valid2, 0);
        check_val("mid_rst_addr", addr2, 0);
        check_val("mid_rst_done", done2, 0);
        check_val("mid_rst_last", last2, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_xfer(13'h0300, 2, 0);

        sel = 1'b1;
        run_xfer(13'h00AB, 8192, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
